// File: rtl/spi_master_m3.sv
// SPI Mode 3 (CPOL=1, CPHA=1) byte master with a start/ready/done handshake
// and an optional slave-select hold that keeps ss low across multi-byte frames.
module spi_master_m3 #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       start,
    input  logic [7:0] tdata,
    input  logic       mlb,
    input  logic       hold,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sck,
    output logic       ss,
    output logic       sdout,
    input  logic       sdin
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_TRAIL,
        S_HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] treg_q, treg_d;
    logic [7:0] rreg_q, rreg_d;
    logic       mlb_q, mlb_d;
    logic       hold_q, hold_d;
    logic       sck_q, sck_d;
    logic       ss_q, ss_d;
    logic       sdout_q, sdout_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;

    logic       tick;
    logic       accept;
    logic       tx_bit;
    logic [7:0] rreg_next;
    logic [7:0] treg_next;

    // In HOLD the done cycle still reports not-ready, so a start coincident
    // with done is dropped and the next byte can only begin one cycle later.
    assign ready     = (state_q == S_IDLE) || ((state_q == S_HOLD) && !done_q);
    assign accept    = start && ready;
    assign tick      = (cnt_q == DIV_LAST);
    assign tx_bit    = mlb_q ? treg_q[7] : treg_q[0];
    assign rreg_next = mlb_q ? {rreg_q[6:0], sdin} : {sdin, rreg_q[7:1]};
    assign treg_next = mlb_q ? {treg_q[6:0], 1'b1} : {1'b1, treg_q[7:1]};

    always_comb begin
        // NOTE: every *_d gets its default first so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        treg_d    = treg_q;
        rreg_d    = rreg_q;
        mlb_d     = mlb_q;
        hold_d    = hold_q;
        sck_d     = sck_q;
        ss_d      = ss_q;
        sdout_d   = sdout_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE, S_HOLD: begin
                cnt_d = '0;
                if (accept) begin
                    treg_d    = tdata;
                    mlb_d     = mlb;
                    hold_d    = hold;
                    rreg_d    = '0;
                    bit_cnt_d = '0;
                    ss_d      = 1'b0;
                    state_d   = S_SETUP;
                end
            end

            // Both the select setup time and the high half-period end in a falling edge.
            S_SETUP, S_HIGH: begin
                if (tick) begin
                    cnt_d   = '0;
                    sck_d   = 1'b0;
                    sdout_d = tx_bit;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_LOW: begin
                if (tick) begin
                    cnt_d  = '0;
                    sck_d  = 1'b1;
                    rreg_d = rreg_next;
                    treg_d = treg_next;
                    if (bit_cnt_q == 3'd7) begin
                        rdata_d   = rreg_next;
                        done_d    = 1'b1;
                        sdout_d   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = hold_q ? S_HOLD : S_TRAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = S_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_TRAIL: begin
                if (tick) begin
                    cnt_d   = '0;
                    ss_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            treg_q    <= '0;
            rreg_q    <= '0;
            mlb_q     <= 1'b0;
            hold_q    <= 1'b0;
            sck_q     <= 1'b1;
            ss_q      <= 1'b1;
            sdout_q   <= 1'b1;
            done_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            treg_q    <= treg_d;
            rreg_q    <= rreg_d;
            mlb_q     <= mlb_d;
            hold_q    <= hold_d;
            sck_q     <= sck_d;
            ss_q      <= ss_d;
            sdout_q   <= sdout_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
        end
    end

    assign sck   = sck_q;
    assign ss    = ss_q;
    assign sdout = sdout_q;
    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_m3.sv
// Self-checking bench for spi_master_m3: a bit-serial Mode 3 slave model and an
// edge/event monitor provide expected data and timing for each scenario.
module tb_spi_master_m3;

    localparam int CD = 4;

    logic       clk    = 1'b0;
    logic       rstb   = 1'b1;
    logic       start  = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] tdata  = 8'h00;
    logic       mlb    = 1'b1;
    logic       hold   = 1'b0;
    logic       sdin   = 1'b1;
    logic       sdin1;

    logic       ready, done, sck, ss, sdout;
    logic [7:0] rdata;
    logic       ready1, done1, sck1, ss1, sdout1;
    logic [7:0] rdata1;

    int errors = 0;
    int checks = 0;

    assign sdin1 = 1'b0;
    always #5 clk = ~clk;

    spi_master_m3 #(.CLK_DIV(CD)) dut (
        .clk(clk), .rstb(rstb), .start(start), .tdata(tdata), .mlb(mlb), .hold(hold),
        .ready(ready), .done(done), .rdata(rdata), .sck(sck), .ss(ss), .sdout(sdout),
        .sdin(sdin)
    );

    spi_master_m3 #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rstb(rstb), .start(start1), .tdata(tdata), .mlb(mlb), .hold(hold),
        .ready(ready1), .done(done1), .rdata(rdata1), .sck(sck1), .ss(ss1), .sdout(sdout1),
        .sdin(sdin1)
    );

    // Event monitor on the CLK_DIV=4 instance, timestamps in clk cycles.
    int         cyc = 0;
    int         mon_fall[$];
    int         mon_rise[$];
    int         mon_done[$];
    int         mon_ssrise[$];
    logic [7:0] mon_rdata[$];
    logic       sck_p = 1'b1;
    logic       ss_p  = 1'b1;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (sck_p && !sck) mon_fall.push_back(cyc);
        if (!sck_p && sck) mon_rise.push_back(cyc);
        if (!ss_p && ss) mon_ssrise.push_back(cyc);
        if (done === 1'b1) begin
            mon_done.push_back(cyc);
            mon_rdata.push_back(rdata);
        end
        sck_p = sck;
        ss_p  = ss;
    end

    // Mode 3 slave: drives MISO on each falling SCK, samples MOSI on each rise.
    logic [7:0] slv_tx[$];
    logic       slv_mlb = 1'b1;
    int         slv_falls = 0;
    int         s_bi, s_ix;
    logic [7:0] s_b;
    logic       slv_mosi = 1'b1;
    logic       rx_bits[$];

    always @(negedge ss) slv_falls = 0;

    always @(negedge sck) begin
        if (!ss) begin
            s_bi = slv_falls / 8;
            s_ix = slv_falls % 8;
            s_b  = (s_bi < slv_tx.size()) ? slv_tx[s_bi] : 8'hFF;
            sdin = slv_mlb ? s_b[3'(7 - s_ix)] : s_b[3'(s_ix)];
            slv_falls++;
            #1 slv_mosi = sdout;
        end
    end

    always @(posedge sck) if (!ss) rx_bits.push_back(slv_mosi);

    function automatic logic [7:0] bits_to_byte(input int off, input logic m);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            if (off + i < rx_bits.size()) begin
                if (m) b[3'(7 - i)] = rx_bits[off + i];
                else   b[3'(i)]     = rx_bits[off + i];
            end
        end
        return b;
    endfunction

    task automatic clear_mon();
        mon_fall.delete();
        mon_rise.delete();
        mon_done.delete();
        mon_ssrise.delete();
        mon_rdata.delete();
        rx_bits.delete();
    endtask

    // Presents one request so that the next posedge (E0) accepts it; returns E0's cycle.
    task automatic issue(input logic [7:0] td, input logic m, input logic h, output int e0);
        @(negedge clk);
        tdata = td;
        mlb   = m;
        hold  = h;
        start = 1'b1;
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
        tdata = 8'($urandom);
        mlb   = 1'($urandom);
        hold  = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1 && ss === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rstb = 1'b0;
        #1;
        checks++; if (sck !== 1'b1)    begin errors++; $display("FAIL reset_sck got=%b exp=1", sck); end
        checks++; if (ss !== 1'b1)     begin errors++; $display("FAIL reset_ss got=%b exp=1", ss); end
        checks++; if (sdout !== 1'b1)  begin errors++; $display("FAIL reset_sdout got=%b exp=1", sdout); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (sck1 !== 1'b1 || ss1 !== 1'b1 || ready1 !== 1'b1)
            begin errors++; $display("FAIL reset_div1 got sck=%b ss=%b ready=%b exp 1 1 1", sck1, ss1, ready1); end
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        clear_mon();
    endtask

    task automatic test_loop_msb();
        int e0, got;
        bit ok;
        clear_mon();
        slv_tx  = {8'h3C};
        slv_mlb = 1'b1;
        issue(8'hA5, 1'b1, 1'b0, e0);
        checks++; if (ss !== 1'b0) begin errors++; $display("FAIL msb_ss_fall got=%b exp=0", ss); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL msb_timeout got=busy exp=idle"); end
        checks++; if (mon_fall.size() != 8 || mon_rise.size() != 8)
            begin errors++; $display("FAIL msb_edges got falls=%0d rises=%0d exp 8 8", mon_fall.size(), mon_rise.size()); end
        for (int k = 0; k < 8; k++) begin
            got = (k < mon_fall.size()) ? mon_fall[k] - e0 : -1;
            checks++; if (got != CD * (1 + 2 * k))
                begin errors++; $display("FAIL msb_fall%0d got=%0d exp=%0d", k, got, CD * (1 + 2 * k)); end
            got = (k < mon_rise.size()) ? mon_rise[k] - e0 : -1;
            checks++; if (got != CD * (2 + 2 * k))
                begin errors++; $display("FAIL msb_rise%0d got=%0d exp=%0d", k, got, CD * (2 + 2 * k)); end
        end
        got = (mon_done.size() == 1) ? mon_done[0] - e0 : -1;
        checks++; if (got != 16 * CD) begin errors++; $display("FAIL msb_done_time got=%0d exp=%0d", got, 16 * CD); end
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL msb_rdata got=%h exp=3c", rdata); end
        checks++; if (bits_to_byte(0, 1'b1) !== 8'hA5)
            begin errors++; $display("FAIL msb_slave_rx got=%h exp=a5", bits_to_byte(0, 1'b1)); end
        got = (mon_ssrise.size() == 1) ? mon_ssrise[0] - e0 : -1;
        checks++; if (got != 17 * CD) begin errors++; $display("FAIL msb_ss_rise got=%0d exp=%0d", got, 17 * CD); end
    endtask

    task automatic test_loop_lsb();
        int e0;
        bit ok;
        logic first_bit;
        clear_mon();
        slv_tx  = {8'h80};
        slv_mlb = 1'b0;
        issue(8'h01, 1'b0, 1'b0, e0);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lsb_timeout got=busy exp=idle"); end
        first_bit = (rx_bits.size() > 0) ? rx_bits[0] : 1'bx;
        checks++; if (first_bit !== 1'b1) begin errors++; $display("FAIL lsb_first_mosi got=%b exp=1", first_bit); end
        checks++; if (rdata !== 8'h80) begin errors++; $display("FAIL lsb_rdata got=%h exp=80", rdata); end
        checks++; if (bits_to_byte(0, 1'b0) !== 8'h01)
            begin errors++; $display("FAIL lsb_slave_rx got=%h exp=01", bits_to_byte(0, 1'b0)); end
        checks++; if (mon_done.size() != 1) begin errors++; $display("FAIL lsb_done_count got=%0d exp=1", mon_done.size()); end
    endtask

    task automatic test_hold_frame();
        int e0a, e0b, got;
        bit ok;
        clear_mon();
        slv_tx  = {8'hF0, 8'h0F};
        slv_mlb = 1'b1;
        issue(8'h12, 1'b1, 1'b1, e0a);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_first_done got=none exp=pulse"); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_ready_on_done got=%b exp=0", ready); end
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hold_ready_after got=%b exp=1", ready); end
        checks++; if (ss !== 1'b0 || sck !== 1'b1 || sdout !== 1'b1)
            begin errors++; $display("FAIL hold_idle_lines got ss=%b sck=%b sdout=%b exp 0 1 1", ss, sck, sdout); end
        issue(8'h34, 1'b1, 1'b0, e0b);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got=busy exp=idle"); end
        checks++; if (mon_fall.size() != 16) begin errors++; $display("FAIL hold_falls got=%0d exp=16", mon_fall.size()); end
        got = (mon_ssrise.size() == 1) ? mon_ssrise[0] - e0b : -1;
        checks++; if (got != 17 * CD)
            begin errors++; $display("FAIL hold_ss_low got ss_rises=%0d rise_at=%0d exp 1 at %0d", mon_ssrise.size(), got, 17 * CD); end
        checks++; if (mon_done.size() != 2) begin errors++; $display("FAIL hold_done_count got=%0d exp=2", mon_done.size()); end
        checks++; if (mon_rdata.size() != 2 || mon_rdata[0] !== 8'hF0 || mon_rdata[1] !== 8'h0F)
            begin errors++; $display("FAIL hold_rdata_seq got n=%0d exp f0,0f", mon_rdata.size()); end
        got = (mon_done.size() == 2) ? mon_done[1] - e0b : -1;
        checks++; if (got != 16 * CD) begin errors++; $display("FAIL hold_done2_time got=%0d exp=%0d", got, 16 * CD); end
        checks++; if (bits_to_byte(0, 1'b1) !== 8'h12 || bits_to_byte(8, 1'b1) !== 8'h34)
            begin errors++; $display("FAIL hold_slave_rx got=%h,%h exp=12,34", bits_to_byte(0, 1'b1), bits_to_byte(8, 1'b1)); end
    endtask

    task automatic test_ignored_start();
        int e0, got;
        bit ok;
        clear_mon();
        slv_tx  = {8'h5A};
        slv_mlb = 1'b1;
        issue(8'hC3, 1'b1, 1'b0, e0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ign_ready_mid got=%b exp=0", ready); end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done got=none exp=pulse"); end
        start = 1'b1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ign_ready_done got=%b exp=0", ready); end
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(100, ok);
        repeat (40) @(negedge clk);
        checks++; if (mon_fall.size() != 8 || mon_rise.size() != 8)
            begin errors++; $display("FAIL ign_edges got falls=%0d rises=%0d exp 8 8", mon_fall.size(), mon_rise.size()); end
        checks++; if (mon_done.size() != 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", mon_done.size()); end
        got = (mon_done.size() > 0) ? mon_done[0] - e0 : -1;
        checks++; if (got != 16 * CD) begin errors++; $display("FAIL ign_done_time got=%0d exp=%0d", got, 16 * CD); end
        checks++; if (ss !== 1'b1 || mon_ssrise.size() != 1)
            begin errors++; $display("FAIL ign_ss got ss=%b rises=%0d exp 1 1", ss, mon_ssrise.size()); end
        checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL ign_rdata got=%h exp=5a", rdata); end
    endtask

    task automatic test_reset_mid();
        int e0, got;
        bit ok;
        clear_mon();
        slv_tx  = {8'h77};
        slv_mlb = 1'b1;
        issue(8'h86, 1'b1, 1'b0, e0);
        repeat (30) @(posedge clk);
        #1;
        checks++; if (sck !== 1'b0 || sdout !== 1'b0)
            begin errors++; $display("FAIL rstmid_pre got sck=%b sdout=%b exp 0 0", sck, sdout); end
        #1 rstb = 1'b0;
        #1;
        checks++; if (sck !== 1'b1)    begin errors++; $display("FAIL rstmid_sck got=%b exp=1", sck); end
        checks++; if (ss !== 1'b1)     begin errors++; $display("FAIL rstmid_ss got=%b exp=1", ss); end
        checks++; if (sdout !== 1'b1)  begin errors++; $display("FAIL rstmid_sdout got=%b exp=1", sdout); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rstmid_rdata got=%h exp=00", rdata); end
        checks++; if (done !== 1'b0 || ready !== 1'b1)
            begin errors++; $display("FAIL rstmid_hs got done=%b ready=%b exp 0 1", done, ready); end
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        clear_mon();
        slv_tx  = {8'hC4};
        slv_mlb = 1'b0;
        issue(8'h3B, 1'b0, 1'b0, e0);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_after_timeout got=busy exp=idle"); end
        checks++; if (rdata !== 8'hC4) begin errors++; $display("FAIL rstmid_after_rdata got=%h exp=c4", rdata); end
        checks++; if (bits_to_byte(0, 1'b0) !== 8'h3B)
            begin errors++; $display("FAIL rstmid_after_slave got=%h exp=3b", bits_to_byte(0, 1'b0)); end
        got = (mon_done.size() == 1) ? mon_done[0] - e0 : -1;
        checks++; if (got != 16 * CD) begin errors++; $display("FAIL rstmid_after_done got=%0d exp=%0d", got, 16 * CD); end
    endtask

    task automatic test_clkdiv1();
        int   falls[$];
        int   rises[$];
        int   dn[$];
        int   got;
        logic sck_prev;
        logic ss16, ss17;
        ss16 = 1'bx;
        ss17 = 1'bx;
        @(negedge clk);
        tdata  = 8'hFF;
        mlb    = 1'b1;
        hold   = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        checks++; if (ss1 !== 1'b0) begin errors++; $display("FAIL div1_ss_fall got=%b exp=0", ss1); end
        sck_prev = sck1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1;
            if (sck_prev && !sck1) falls.push_back(n);
            if (!sck_prev && sck1) rises.push_back(n);
            if (done1 === 1'b1) dn.push_back(n);
            if (n == 16) ss16 = ss1;
            if (n == 17) ss17 = ss1;
            sck_prev = sck1;
        end
        checks++; if (falls.size() != 8 || rises.size() != 8)
            begin errors++; $display("FAIL div1_edges got falls=%0d rises=%0d exp 8 8", falls.size(), rises.size()); end
        for (int k = 0; k < 8; k++) begin
            got = (k < falls.size()) ? falls[k] : -1;
            checks++; if (got != 1 + 2 * k) begin errors++; $display("FAIL div1_fall%0d got=%0d exp=%0d", k, got, 1 + 2 * k); end
            got = (k < rises.size()) ? rises[k] : -1;
            checks++; if (got != 2 + 2 * k) begin errors++; $display("FAIL div1_rise%0d got=%0d exp=%0d", k, got, 2 + 2 * k); end
        end
        got = (dn.size() == 1) ? dn[0] : -1;
        checks++; if (got != 16) begin errors++; $display("FAIL div1_done got=%0d exp=16", got); end
        checks++; if (rdata1 !== 8'h00) begin errors++; $display("FAIL div1_rdata got=%h exp=00", rdata1); end
        checks++; if (ss16 !== 1'b0 || ss17 !== 1'b1)
            begin errors++; $display("FAIL div1_ss_rise got ss16=%b ss17=%b exp 0 1", ss16, ss17); end
        checks++; if (ready1 !== 1'b1 || sdout1 !== 1'b1)
            begin errors++; $display("FAIL div1_idle got ready=%b sdout=%b exp 1 1", ready1, sdout1); end
    endtask

    task automatic test_random();
        int         e0, got;
        bit         ok;
        logic [7:0] tx, sx;
        logic       m;
        for (int it = 0; it < 16; it++) begin
            tx = 8'($urandom);
            sx = 8'($urandom);
            m  = 1'($urandom);
            clear_mon();
            slv_tx  = {sx};
            slv_mlb = m;
            issue(tx, m, 1'b0, e0);
            wait_idle(200, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got=busy exp=idle", it); end
            checks++; if (rdata !== sx) begin errors++; $display("FAIL rand%0d_rdata got=%h exp=%h", it, rdata, sx); end
            checks++; if (bits_to_byte(0, m) !== tx)
                begin errors++; $display("FAIL rand%0d_slave got=%h exp=%h", it, bits_to_byte(0, m), tx); end
            got = (mon_done.size() == 1) ? mon_done[0] - e0 : -1;
            checks++; if (got != 16 * CD) begin errors++; $display("FAIL rand%0d_done got=%0d exp=%0d", it, got, 16 * CD); end
        end
    endtask

    initial begin
        test_reset();
        test_loop_msb();
        test_loop_lsb();
        test_hold_frame();
        test_ignored_start();
        test_reset_mid();
        test_clkdiv1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
